instr_fetch_buffer: RTL and testbench

INSTR_FETCH_BUFFER -- requirements
Module: instr_fetch_buffer

---
 rtl/instr_fetch_buffer_pkg.sv | 22 ++
 rtl/instr_fetch_buffer_sync_fifo.sv | 62 ++++++
 rtl/instr_fetch_buffer.sv | 125 ++++++++++++
 tb/tb_instr_fetch_buffer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_buffer_pkg.sv
// Shared core constants and types for the instruction fetch buffer.
package instr_fetch_buffer_pkg;

   localparam int XLEN = 32;
   localparam int ILEN = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic {
      ST_FETCH = 1'b0,
      ST_DRAIN = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] data;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/instr_fetch_buffer_sync_fifo.sv
// Synchronous FIFO with flush and occupancy count; DEPTH must be a power of two.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_clear,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_wdata,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_rdata,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_full;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_count == '0);
   assign w_full    = (r_count == FULL_COUNT);
   assign w_do_pop  = i_pop && !o_empty;
   // A push into a full FIFO is legal when the head leaves in the same cycle.
   assign w_do_push = i_push && (!w_full || w_do_pop);
   assign o_rdata   = r_mem[r_rd_ptr];
   assign o_count   = r_count;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: ;
         endcase
      end
   end

   // NOTE: storage is not reset; r_count alone decides which slots hold live data.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
   end

endmodule

// File: rtl/instr_fetch_buffer.sv
// Instruction prefetch buffer: credit-limited fetch, in-order response queue, redirect with response drain.
module instr_fetch_buffer
   import instr_fetch_buffer_pkg::*;
#(
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   output logic            mem_req_valid,
   input  logic            mem_req_ready,
   output logic [XLEN-1:0] mem_req_addr,
   input  logic            mem_rsp_valid,
   input  logic [ILEN-1:0] mem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [ILEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] CREDIT_LIMIT = (CW+1)'(DEPTH);

   fetch_state_e    r_state;
   fetch_state_e    w_state_nxt;
   logic [CW-1:0]   r_drop_cnt;
   logic [CW-1:0]   w_drop_nxt;
   logic [XLEN-1:0] r_fetch_pc;
   logic [XLEN-1:0] w_fetch_pc_nxt;

   logic [CW-1:0]   w_entry_count;
   logic [CW-1:0]   w_addrq_count;
   logic [CW-1:0]   w_outstanding;
   logic [CW:0]     w_credit_used;
   logic            w_entry_empty;
   logic            w_addrq_empty;
   logic [XLEN-1:0] w_addr_head;
   fetch_entry_t    w_head;
   fetch_entry_t    w_tail;
   logic            w_req_fire;
   logic            w_rsp_live;
   logic            w_rsp_drop;
   logic            w_pop;

   // Every request not yet answered: live ones sit in the address queue, dropped ones in r_drop_cnt.
   assign w_outstanding = r_drop_cnt + w_addrq_count;
   assign w_credit_used = {1'b0, w_entry_count} + {1'b0, w_outstanding};

   assign mem_req_valid = rst && (w_credit_used < CREDIT_LIMIT) && !redirect_valid
                          && (r_state == ST_FETCH);
   assign mem_req_addr  = r_fetch_pc;
   assign w_req_fire    = mem_req_valid && mem_req_ready;

   assign w_rsp_live = mem_rsp_valid && !redirect_valid && (r_state == ST_FETCH) && !w_addrq_empty;
   assign w_rsp_drop = mem_rsp_valid && !redirect_valid && (r_state == ST_DRAIN);
   assign w_tail     = '{pc: w_addr_head, data: mem_rsp_data};

   assign instr_valid = !w_entry_empty;
   assign w_pop       = instr_valid && instr_ready;
   assign instr       = instr_valid ? w_head.data : '0;
   assign instr_pc    = instr_valid ? w_head.pc   : '0;

   sync_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (DEPTH)
   ) u_entry_fifo (
      .clk     (clk),
      .rst_n   (rst),
      .i_clear (redirect_valid),
      .i_push  (w_rsp_live),
      .i_wdata (w_tail),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_empty (w_entry_empty),
      .o_count (w_entry_count)
   );

   sync_fifo #(
      .WIDTH (XLEN),
      .DEPTH (DEPTH)
   ) u_addr_queue (
      .clk     (clk),
      .rst_n   (rst),
      .i_clear (redirect_valid),
      .i_push  (w_req_fire),
      .i_wdata (r_fetch_pc),
      .i_pop   (w_rsp_live),
      .o_rdata (w_addr_head),
      .o_empty (w_addrq_empty),
      .o_count (w_addrq_count)
   );

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_drop_nxt     = r_drop_cnt;
      w_fetch_pc_nxt = r_fetch_pc;
      case (r_state)
         ST_FETCH: if (w_req_fire) w_fetch_pc_nxt = r_fetch_pc + XLEN'(4);
         ST_DRAIN: if (w_rsp_drop && r_drop_cnt != '0) w_drop_nxt = r_drop_cnt - 1'b1;
         default:  ;
      endcase
      // A response in the redirect cycle is itself discarded, so it leaves the count.
      if (redirect_valid) begin
         w_fetch_pc_nxt = align_word(redirect_pc);
         w_drop_nxt     = (mem_rsp_valid && w_outstanding != '0) ? w_outstanding - 1'b1
                                                                 : w_outstanding;
      end
      w_state_nxt = (w_drop_nxt != '0) ? ST_DRAIN : ST_FETCH;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_FETCH;
         r_drop_cnt <= '0;
         r_fetch_pc <= RESET_PC;
      end else begin
         r_state    <= w_state_nxt;
         r_drop_cnt <= w_drop_nxt;
         r_fetch_pc <= w_fetch_pc_nxt;
      end
   end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Randomised bench: memory model + transaction-level reference for the fetch buffer.
module tb_instr_fetch_buffer;
   import instr_fetch_buffer_pkg::*;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;

   instr_fetch_buffer #(
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_rsp_valid  (mem_rsp_valid),
      .mem_rsp_data   (mem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      bit          live;
      int          due;
   } mem_txn_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } exp_t;

   mem_txn_t    mem_q[$];   // requests held by the memory model
   exp_t        exp_q[$];   // scoreboard: instructions the buffer must hold, in order
   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          n_accepts = 0;
   logic [31:0] m_req_pc;
   logic [31:0] m_stream_pc;

   int          p_ready, p_iready, p_rsp, lat_min, lat_max, redir_permil;
   bit          force_redir;
   logic [31:0] force_pc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
   endfunction

   function automatic int stale_count();
      int n = 0;
      foreach (mem_q[i]) if (!mem_q[i].live) n++;
      return n;
   endfunction

   function automatic logic [31:0] rand_target();
      logic [31:0] t;
      if ($urandom_range(3) == 0) t = 32'hFFFF_FFF0 | 32'($urandom_range(15));
      else                        t = 32'($urandom_range(1023));
      return t;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Drive one cycle of stimulus shortly after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      mem_req_ready = ($urandom_range(99) < p_ready);
      instr_ready   = ($urandom_range(99) < p_iready);
      if (force_redir) begin
         redirect_valid = 1'b1;
         redirect_pc    = force_pc;
         force_redir    = 1'b0;
      end else if ($urandom_range(999) < redir_permil) begin
         redirect_valid = 1'b1;
         redirect_pc    = rand_target();
      end else begin
         redirect_valid = 1'b0;
      end
      if (mem_q.size() > 0 && mem_q[0].due <= cyc && $urandom_range(99) < p_rsp) begin
         mem_rsp_valid = 1'b1;
         mem_rsp_data  = mem_word(mem_q[0].addr);
      end else begin
         mem_rsp_valid = 1'b0;
         mem_rsp_data  = $urandom;
      end
   endtask

   task automatic settle();
      @(negedge clk);
      #2;
   endtask

   task automatic drain();
      p_ready = 0; p_iready = 100; p_rsp = 100; redir_permil = 0;
      for (int i = 0; i < 100 && !(mem_q.size() == 0 && exp_q.size() == 0); i++) step();
      check("drain_timeout", (mem_q.size() == 0 && exp_q.size() == 0), 1);
   endtask

   // Monitor: compare the buffer head and flow control against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (rst === 1'b1) begin
            check("instr_valid", instr_valid, exp_q.size() != 0);
            check("mem_req_valid", mem_req_valid,
                  (exp_q.size() + mem_q.size() < DEPTH) && !redirect_valid && stale_count() == 0);
            if (instr_valid && exp_q.size() != 0) begin
               check("instr_pc", instr_pc, exp_q[0].pc);
               check("instr", instr, exp_q[0].data);
               if (instr_ready && !redirect_valid) void'(exp_q.pop_front());
            end
         end
      end
   end

   // Memory and stream model: applies the cycle's events after the monitor has sampled.
   initial begin
      mem_txn_t t;
      logic [31:0] tgt;
      forever begin
         @(negedge clk);
         #1;
         if (rst === 1'b1) begin
            if (redirect_valid) begin
               if (mem_rsp_valid && mem_q.size() > 0) void'(mem_q.pop_front());
               foreach (mem_q[i]) mem_q[i].live = 1'b0;
               exp_q.delete();
               tgt         = redirect_pc;
               m_req_pc    = {tgt[31:2], 2'b00};
               m_stream_pc = m_req_pc;
            end else begin
               if (mem_rsp_valid && mem_q.size() > 0) begin
                  t = mem_q.pop_front();
                  if (t.live) begin
                     exp_q.push_back('{m_stream_pc, mem_word(m_stream_pc)});
                     m_stream_pc = m_stream_pc + 32'd4;
                  end
               end
               if (mem_req_valid && mem_req_ready) begin
                  n_accepts++;
                  check("req_addr", mem_req_addr, m_req_pc);
                  mem_q.push_back('{mem_req_addr, 1'b1, cyc + $urandom_range(lat_max, lat_min)});
                  m_req_pc = m_req_pc + 32'd4;
               end
            end
         end
      end
   end

   initial begin
      int base;
      rst = 1'b0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
      redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
      p_ready = 100; p_iready = 100; p_rsp = 100; lat_min = 1; lat_max = 1;
      redir_permil = 0; force_redir = 1'b0; force_pc = '0;
      m_req_pc = RESET_PC; m_stream_pc = RESET_PC;

      #1;
      check("rst_instr_valid", instr_valid, 0);
      check("rst_mem_req_valid", mem_req_valid, 0);
      check("rst_instr", instr, 0);
      check("rst_instr_pc", instr_pc, 0);
      repeat (3) step();
      #1 rst = 1'b1;

      // Streaming with a one-cycle memory
      repeat (20) step();

      // Decode stalled: credits cap requests at DEPTH, one pop frees exactly one
      drain();
      settle();
      base = n_accepts;
      p_iready = 0; p_ready = 100; lat_min = 1; lat_max = 1;
      repeat (12) step();
      settle();
      check("fill_accepts", n_accepts - base, DEPTH);
      base = n_accepts;
      p_iready = 100;
      step();
      p_iready = 0;
      repeat (8) step();
      settle();
      check("one_pop_one_req", n_accepts - base, 1);

      // Full buffer with continuous pop and refill
      p_iready = 100;
      repeat (20) step();

      // Redirect with two outstanding requests
      drain();
      lat_min = 6; lat_max = 6; p_ready = 100;
      step();
      step();
      p_ready = 0; force_redir = 1'b1; force_pc = 32'h0000_0100;
      step();
      p_ready = 100; lat_min = 1; lat_max = 1;
      repeat (25) step();

      // Unaligned redirect target
      force_redir = 1'b1; force_pc = 32'h0000_0203;
      repeat (15) step();

      // Randomised traffic
      for (int chunk = 0; chunk < 15; chunk++) begin
         p_ready      = $urandom_range(100, 30);
         p_iready     = $urandom_range(100, 20);
         p_rsp        = $urandom_range(100, 50);
         lat_min      = 1;
         lat_max      = $urandom_range(5, 1);
         redir_permil = 25;
         repeat (200) step();
      end

      // Reset in the middle of a burst with three requests outstanding
      drain();
      lat_min = 3; lat_max = 3; p_ready = 100; p_iready = 0;
      for (int i = 0; i < 30 && !(exp_q.size() >= 1 && mem_q.size() >= 3); i++) step();
      check("burst_outstanding", mem_q.size(), 3);
      check("pre_rst_instr_valid", instr_valid, 1);
      #1 rst = 1'b0;
      #1;
      check("midrst_instr_valid", instr_valid, 0);
      check("midrst_mem_req_valid", mem_req_valid, 0);
      check("midrst_instr", instr, 0);
      check("midrst_instr_pc", instr_pc, 0);
      mem_q.delete();
      exp_q.delete();
      m_req_pc = RESET_PC; m_stream_pc = RESET_PC;
      repeat (2) step();
      p_iready = 100; lat_min = 1; lat_max = 1;
      step();
      #1 rst = 1'b1;
      repeat (20) step();
      drain();
      settle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
